// File: rtl/mem_access_unit.sv
// Memory-stage data-access controller driving the SRAM-like data bus (req/addr_ok/data_ok).
// Optional macro ADDR_ERR_EN: misaligned-address detection; otherwise addresses are forced aligned.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_enM,
    input  logic        mem_write_enM,
    input  logic [31:0] mem_addrM,
    input  logic [31:0] rt_valueM,
    input  logic [1:0]  ls_sizeM,
    input  logic        ls_unsignedM,
    input  logic        flush_excM,
    input  logic        advanceM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_reqM,
    output logic [31:0] load_dataM,
    output logic        addr_errM,
    output logic [31:0] badvaddrM
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [1:0]  size_code_s;
    logic [31:0] eff_addr_s;
    logic        addr_err_s;
    logic        access_s;
    logic [3:0]  strb_raw_s, wstrb_s;
    logic [31:0] wdata_s;
    logic        latch_s, capture_s, set_kill_s;
    logic [31:0] addr_r, wdata_r, result_r;
    logic [3:0]  wstrb_r;
    logic [1:0]  size_r;
    logic        wr_r, uns_r, killed_r;
    logic [1:0]  cur_lane_s, cur_size_s;
    logic        cur_uns_s, cur_wr_s;

    function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    r = {{24{~uns & b[7]}}, b};
            2'd1:    r = {{16{~uns & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Size encoding: 3 behaves as a word access
    always_comb begin
        if (ls_sizeM == 2'd0) begin
            size_code_s = 2'd0;
        end else if (ls_sizeM == 2'd1) begin
            size_code_s = 2'd1;
        end else begin
            size_code_s = 2'd2;
        end
    end

`ifdef ADDR_ERR_EN
    // Misalignment check on the live M-stage address
    always_comb begin
        eff_addr_s = mem_addrM;
        badvaddrM  = mem_addrM;
        addr_err_s = (mem_read_enM | mem_write_enM) &
                     (((size_code_s == 2'd1) & mem_addrM[0]) |
                      ((size_code_s == 2'd2) & (mem_addrM[1:0] != 2'b00)));
    end
`else
    // Without detection the low address bits are dropped to the access size
    always_comb begin
        eff_addr_s = mem_addrM;
        badvaddrM  = 32'h0000_0000;
        addr_err_s = 1'b0;
        if (size_code_s == 2'd1) begin
            eff_addr_s[0] = 1'b0;
        end else if (size_code_s == 2'd2) begin
            eff_addr_s[1:0] = 2'b00;
        end else begin
            eff_addr_s = mem_addrM;
        end
    end
`endif

    assign addr_errM = addr_err_s;
    assign access_s  = (mem_read_enM | mem_write_enM) & ~addr_err_s & ~flush_excM;

    // Byte strobes and lane-replicated store data
    always_comb begin
        case (size_code_s)
            2'd0: begin
                strb_raw_s = 4'b0001 << eff_addr_s[1:0];
                wdata_s    = {4{rt_valueM[7:0]}};
            end
            2'd1: begin
                strb_raw_s = eff_addr_s[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{rt_valueM[15:0]}};
            end
            default: begin
                strb_raw_s = 4'b1111;
                wdata_s    = rt_valueM;
            end
        endcase
    end

    assign wstrb_s = mem_write_enM ? strb_raw_s : 4'b0000;

    // Request fields come straight from the pipeline in IDLE, from the latch afterwards
    always_comb begin
        if (state_r == IDLE) begin
            data_addr  = eff_addr_s;
            data_wr    = mem_write_enM;
            data_size  = size_code_s;
            data_wstrb = wstrb_s;
            data_wdata = wdata_s;
            cur_lane_s = eff_addr_s[1:0];
            cur_size_s = size_code_s;
            cur_uns_s  = ls_unsignedM;
            cur_wr_s   = mem_write_enM;
        end else begin
            data_addr  = addr_r;
            data_wr    = wr_r;
            data_size  = size_r;
            data_wstrb = wstrb_r;
            data_wdata = wdata_r;
            cur_lane_s = addr_r[1:0];
            cur_size_s = size_r;
            cur_uns_s  = uns_r;
            cur_wr_s   = wr_r;
        end
    end

    // Next-state, bus request and stall generation
    always_comb begin
        state_next_s = state_r;
        data_req     = 1'b0;
        stall_reqM   = 1'b0;
        latch_s      = 1'b0;
        capture_s    = 1'b0;
        set_kill_s   = 1'b0;
        case (state_r)
            IDLE: begin
                data_req   = access_s;
                stall_reqM = access_s;
                if (access_s) begin
                    latch_s = 1'b1;
                    if (data_addr_ok && data_data_ok) begin
                        capture_s    = 1'b1;
                        state_next_s = DONE;
                    end else if (data_addr_ok) begin
                        state_next_s = WAIT_DATA;
                    end else begin
                        state_next_s = WAIT_ADDR;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ADDR: begin
                data_req   = 1'b1;
                stall_reqM = 1'b1;
                set_kill_s = flush_excM;
                if (data_addr_ok && data_data_ok) begin
                    if (killed_r || flush_excM) begin
                        state_next_s = IDLE;
                    end else begin
                        capture_s    = 1'b1;
                        state_next_s = DONE;
                    end
                end else if (data_addr_ok) begin
                    state_next_s = WAIT_DATA;
                end else begin
                    state_next_s = WAIT_ADDR;
                end
            end
            WAIT_DATA: begin
                stall_reqM = 1'b1;
                set_kill_s = flush_excM;
                if (data_data_ok) begin
                    if (killed_r || flush_excM) begin
                        state_next_s = IDLE;
                    end else begin
                        capture_s    = 1'b1;
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = WAIT_DATA;
                end
            end
            DONE: begin
                if (advanceM) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, kill flag, latched request and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            killed_r <= 1'b0;
            result_r <= 32'h0000_0000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            wstrb_r  <= 4'b0000;
            size_r   <= 2'd0;
            wr_r     <= 1'b0;
            uns_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s == IDLE) begin
                killed_r <= 1'b0;
            end else if (set_kill_s) begin
                killed_r <= 1'b1;
            end else begin
                killed_r <= killed_r;
            end
            if (latch_s) begin
                addr_r  <= eff_addr_s;
                wdata_r <= wdata_s;
                wstrb_r <= wstrb_s;
                size_r  <= size_code_s;
                wr_r    <= mem_write_enM;
                uns_r   <= ls_unsignedM;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                wstrb_r <= wstrb_r;
                size_r  <= size_r;
                wr_r    <= wr_r;
                uns_r   <= uns_r;
            end
            if (capture_s) begin
                result_r <= cur_wr_s ? 32'h0000_0000
                                     : extend_load(data_rdata, cur_lane_s, cur_size_s, cur_uns_s);
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign load_dataM = (state_r == DONE) ? result_r : 32'h0000_0000;

endmodule
